// File: rtl/param_fifo.sv
// Single-clock FIFO with registered read data and registered count/status flags.
// Latency: one clock from accepted pop to data_out; push is refused only when full without a pop.
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              push,
  input  logic              pop,
  output logic [WIDTH-1:0]  data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   C_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   C_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_AFULL   = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0]   C_AEMPTY  = AEMPTY_TH[ADDR_W:0];

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_udf;

  logic              w_pop_ok;
  logic              w_push_ok;
  logic [ADDR_W:0]   w_count_nxt;

  // A pop frees a slot in the same edge, so a push into a full FIFO is legal alongside it.
  assign w_pop_ok  = pop && !r_empty;
  assign w_push_ok = push && (!r_full || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + C_CNT_ONE;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - C_CNT_ONE;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Flags are derived from the next count so they never lag count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == C_DEPTH);
      r_afull  <= (w_count_nxt >= C_AFULL);
      r_aempty <= (w_count_nxt <= C_AEMPTY);
      r_ovf    <= push && !w_push_ok;
      r_udf    <= pop && r_empty;
    end
  end

  assign data_out     = r_data_out;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (default parameters: 8 x 8-bit, afull 6, aempty 2).
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_total = 0;
  int n_bad   = 0;

  param_fifo #(.WIDTH(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .push        (push),
    .pop         (pop),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, sample 1 time unit after the edge, then go idle.
  task automatic cyc(input logic p_push, input logic p_pop, input logic [7:0] p_din);
    push    = p_push;
    pop     = p_pop;
    data_in = p_din;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " data_out"}, 32'(data_out), 32'h0);
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " empty"}, 32'(empty), 32'd1);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " aempty"}, 32'(almost_empty), 32'd1);
    chk({tag, " afull"}, 32'(almost_full), 32'd0);
    chk({tag, " ovf"}, 32'(overflow), 32'd0);
    chk({tag, " udf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fill 0x11..0x18, then an overflowing push.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h11 + i));
      chk($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
      chk($sformatf("fill%0d afull", i), 32'(almost_full), 32'(i + 1 >= 6));
      chk($sformatf("fill%0d aempty", i), 32'(almost_empty), 32'(i + 1 <= 2));
      chk($sformatf("fill%0d empty", i), 32'(empty), 32'd0);
    end
    chk("fill full", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 8'h99);
    chk("ovf pulse", 32'(overflow), 32'd1);
    chk("ovf count", 32'(count), 32'd8);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ovf clear", 32'(overflow), 32'd0);

    // Drain in order, then an underflowing pop.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d data", i), 32'(data_out), 32'(8'h11 + i));
      chk($sformatf("drain%0d count", i), 32'(count), 32'(7 - i));
      chk($sformatf("drain%0d full", i), 32'(full), 32'd0);
      chk($sformatf("drain%0d aempty", i), 32'(almost_empty), 32'(7 - i <= 2));
    end
    chk("drain empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf pulse", 32'(underflow), 32'd1);
    chk("udf data hold", 32'(data_out), 32'h18);
    cyc(1'b0, 1'b0, 8'h00);
    chk("udf clear", 32'(underflow), 32'd0);

    // Push and pop together while empty.
    cyc(1'b1, 1'b1, 8'hA5);
    chk("ep count", 32'(count), 32'd1);
    chk("ep udf", 32'(underflow), 32'd1);
    chk("ep data hold", 32'(data_out), 32'h18);
    cyc(1'b0, 1'b1, 8'h00);
    chk("ep pop data", 32'(data_out), 32'hA5);
    chk("ep pop empty", 32'(empty), 32'd1);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h21 + i));
    cyc(1'b1, 1'b1, 8'h5A);
    chk("fp data", 32'(data_out), 32'h21);
    chk("fp count", 32'(count), 32'd8);
    chk("fp full", 32'(full), 32'd1);
    chk("fp ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("fp drain%0d", i), 32'(data_out), (i < 7) ? 32'(8'h22 + i) : 32'h5A);
    end
    chk("fp drain empty", 32'(empty), 32'd1);

    // Steady state at count 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h40 + i));
      chk($sformatf("ss%0d data", i), 32'(data_out), (i < 3) ? 32'(8'h30 + i) : 32'(8'h40 + i - 3));
      chk($sformatf("ss%0d count", i), 32'(count), 32'd3);
      chk($sformatf("ss%0d aempty", i), 32'(almost_empty), 32'd0);
      chk($sformatf("ss%0d afull", i), 32'(almost_full), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("ss tail%0d", i), 32'(data_out), 32'(8'h51 + i));
    end

    // Asynchronous reset between edges with count 5 and a push in flight.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h61 + i));
    chk("mr count before", 32'(count), 32'd5);
    push    = 1'b1;
    data_in = 8'hEE;
    #2 reset = 1'b1;
    #1 chk_reset_state("mr");
    chk("mr wr_ptr", 32'(dut.r_wr_ptr), 32'd0);
    chk("mr rd_ptr", 32'(dut.r_rd_ptr), 32'd0);
    push = 1'b0;
    @(posedge clk);
    #1 chk("mr held count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 8'h77);
    chk("mr push count", 32'(count), 32'd1);
    chk("mr push slot0", 32'(dut.r_mem[0]), 32'h77);
    cyc(1'b0, 1'b1, 8'h00);
    chk("mr pop data", 32'(data_out), 32'h77);
    chk("mr pop empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
